mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester arbiter and sequencer for the CPU's single-port synchronous data memory. It shares the memory between the CPU control path (memory read/write commands) and a host/debug port used for loading and inspecting memory. It runs each granted access through a fixed ACCESS/CAPTURE/DONE sequence, latches the request fields at grant, and returns read data in a per-requester holding register. Fairness is round-robin.

## Interface
- N, default 8: data width in bits.
- ADDR_W, default 4: memory address width in bits.

- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- cpu_req  in  1  CPU access request, level.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  N  CPU write data.
- cpu_gnt  out  1  high for the one ACCESS cycle of a CPU access.
- cpu_done  out  1  high for the one DONE cycle of a CPU access.
- cpu_rdata  out  N  last CPU read result, held.
- host_req, host_we, host_addr, host_wdata  in  1/1/ADDR_W/N  host-side equivalents.
- host_gnt, host_done  out  1  host-side equivalents.
- host_rdata  out  N  host-side equivalent.
- mem_re  out  1  memory read strobe.
- mem_we  out  1  memory write strobe.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  N  memory write data.
- mem_rdata  in  N  memory read data, valid the cycle after mem_re.

## Operation
- States: IDLE, ACCESS, CAPTURE, DONE. Encoding is 2 bits.
- Arbitration points are IDLE and DONE.
  - If no request is pending, the next state is IDLE.
  - If a request is pending, the next state is ACCESS.
- Winner selection:
  - With only one req high, that requester wins.
  - With both high, the requester not served last wins.
  - The last-served pointer resets to "host", so the CPU wins the first tie.
- On the edge entering ACCESS, the arbiter latches the winner's id, we, addr and wdata into internal registers and updates the last-served pointer. Requester inputs are ignored until the next arbitration point.
- ACCESS:
  - gnt of the winner = 1.
  - mem_addr and mem_wdata come from the latched fields.
  - mem_we = latched we; mem_re = !latched we.
  - Next state is CAPTURE.
- CAPTURE:
  - All strobes are 0.
  - For a latched read, the winner's rdata register loads mem_rdata on the exiting edge.
  - For a write, no rdata register changes.
  - Next state is DONE.
- DONE:
  - done of the winner = 1.
  - That requester's rdata is valid from this cycle and held until its next read completes.
- req is sampled in the DONE cycle, including the finishing requester's own req.
  - A requester that keeps req high issues a new request.
  - When both requesters want the memory, round-robin applies, so a persistent requester cannot starve the other.
- A requester dropping req after being granted does not cancel the access; it completes normally.
- mem_addr and mem_wdata hold their last latched values outside ACCESS. Only the strobes qualify them.
- Only one gnt, one done and one strobe are ever high at a time.

## Timing
- Reset values:
  - state = IDLE, last-served = host.
  - All gnt, done, mem_re and mem_we = 0.
  - mem_addr, mem_wdata, cpu_rdata and host_rdata = 0.
- All outputs are registered or decoded from state plus latched registers. There is no combinational path from any req input to any output.
- Latency from req sampled high in IDLE:
  - gnt one cycle later.
  - Memory strobe in the same cycle as gnt.
  - done three cycles after the req sample edge.
- Back-to-back period is 3 cycles per access: ACCESS, CAPTURE, DONE, then ACCESS again.
- rst asserted mid-sequence:
  - Immediate return to IDLE and strobes drop asynchronously.
  - The in-flight access is abandoned with no done.
  - A write in ACCESS may or may not have been committed by the memory.
- After rst deasserts, the first arbitration is on the first rising edge in IDLE.

## Test plan
- CPU write addr 4'h3 data 8'hA5, then CPU read addr 4'h3:
  - mem_we for exactly 1 cycle with addr 3 and data A5.
  - Read done 3 cycles after the read request.
  - cpu_rdata = 8'hA5 held; host_rdata stays 0.
- cpu_req and host_req both held high for 4 accesses from reset: grant order is cpu, host, cpu, host with a 3-cycle spacing between gnt pulses.
- Host alone holds req for 3 reads (addr 1, 2, 3):
  - gnt pulses 3 cycles apart.
  - host_rdata updates at each DONE.
  - cpu_* outputs stay idle.
- CPU read granted, then cpu_addr and cpu_req changed in the ACCESS cycle: mem_addr keeps the latched value and done still pulses once.
- Host reads addr 5 (8'h3C), then the CPU reads addr 6 (8'h77): host_rdata stays 8'h3C while cpu_rdata becomes 8'h77.
- rst pulsed during CAPTURE of a CPU read:
  - All outputs go to their reset values, with no cpu_done.
  - A new request after reset completes normally, with CPU priority on a tie.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the single-port data memory.
// The slave modport is the arbiter's view; master is the environment's view.
interface mem_arbiter_if #(
    parameter int N      = 8,
    parameter int ADDR_W = 4
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [N-1:0]      cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_done;
    logic [N-1:0]      cpu_rdata;

    logic              host_req;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [N-1:0]      host_wdata;
    logic              host_gnt;
    logic              host_done;
    logic [N-1:0]      host_rdata;

    logic              mem_re;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [N-1:0]      mem_wdata;
    logic [N-1:0]      mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  host_req, host_we, host_addr, host_wdata,
        input  mem_rdata,
        output cpu_gnt, cpu_done, cpu_rdata,
        output host_gnt, host_done, host_rdata,
        output mem_re, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output host_req, host_we, host_addr, host_wdata,
        output mem_rdata,
        input  cpu_gnt, cpu_done, cpu_rdata,
        input  host_gnt, host_done, host_rdata,
        input  mem_re, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin CPU/host arbiter for a single-port synchronous memory; each access runs
// ACCESS -> CAPTURE -> DONE with request fields latched at grant.
module mem_arbiter #(
    parameter int N      = 8,
    parameter int ADDR_W = 4
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    typedef enum logic {
        REQ_CPU  = 1'b0,
        REQ_HOST = 1'b1
    } req_id_t;

    state_t            state, state_next;
    req_id_t           winner, id_q, last_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [N-1:0]      wdata_q;
    logic [N-1:0]      cpu_rdata_q, host_rdata_q;
    logic              start;

    // Requests only matter at an arbitration point; ties go to whoever was not served last.
    always_comb begin
        winner = REQ_CPU;
        if (bus.cpu_req && bus.host_req)
            winner = (last_q == REQ_HOST) ? REQ_CPU : REQ_HOST;
        else if (bus.host_req)
            winner = REQ_HOST;
    end

    assign start = ((state == IDLE) || (state == DONE)) && (bus.cpu_req || bus.host_req);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: default assignment first so no path through this block leaves a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = start ? ACCESS : IDLE;
            ACCESS:  state_next = CAPTURE;
            CAPTURE: state_next = DONE;
            DONE:    state_next = start ? ACCESS : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_q    <= REQ_CPU;
            last_q  <= REQ_HOST;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (start) begin
            id_q    <= winner;
            last_q  <= winner;
            we_q    <= (winner == REQ_CPU) ? bus.cpu_we    : bus.host_we;
            addr_q  <= (winner == REQ_CPU) ? bus.cpu_addr  : bus.host_addr;
            wdata_q <= (winner == REQ_CPU) ? bus.cpu_wdata : bus.host_wdata;
        end
    end

    // Memory data is valid during CAPTURE; only the winner's holding register loads it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpu_rdata_q  <= '0;
            host_rdata_q <= '0;
        end else if (state == CAPTURE && !we_q) begin
            if (id_q == REQ_CPU) cpu_rdata_q  <= bus.mem_rdata;
            else                 host_rdata_q <= bus.mem_rdata;
        end
    end

    always_comb begin
        bus.cpu_gnt   = 1'b0;
        bus.host_gnt  = 1'b0;
        bus.cpu_done  = 1'b0;
        bus.host_done = 1'b0;
        bus.mem_re    = 1'b0;
        bus.mem_we    = 1'b0;
        case (state)
            ACCESS: begin
                bus.cpu_gnt  = (id_q == REQ_CPU);
                bus.host_gnt = (id_q == REQ_HOST);
                bus.mem_we   = we_q;
                bus.mem_re   = !we_q;
            end
            DONE: begin
                bus.cpu_done  = (id_q == REQ_CPU);
                bus.host_done = (id_q == REQ_HOST);
            end
            default: ;
        endcase
    end

    assign bus.mem_addr   = addr_q;
    assign bus.mem_wdata  = wdata_q;
    assign bus.cpu_rdata  = cpu_rdata_q;
    assign bus.host_rdata = host_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small synchronous memory model; each step's
// expectations are hand-derived from the ACCESS/CAPTURE/DONE timing.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   we_cycles = 0;
    int   we_snap;
    logic [7:0] mem [16];

    mem_arbiter_if #(.N(8), .ADDR_W(4)) bus ();

    mem_arbiter #(.N(8), .ADDR_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Single-port memory: read data appears the cycle after mem_re.
    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr];
    end

    always @(negedge clk) if (bus.mem_we) we_cycles++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " gnts"},   {bus.cpu_gnt, bus.host_gnt}, 2'b00);
        check({tag, " dones"},  {bus.cpu_done, bus.host_done}, 2'b00);
        check({tag, " strobes"}, {bus.mem_re, bus.mem_we}, 2'b00);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        mem[1] = 8'h11;
        mem[2] = 8'h22;
        mem[5] = 8'h3C;
        mem[6] = 8'h77;
        bus.mem_rdata  = 8'h00;
        bus.cpu_req    = 1'b0;
        bus.cpu_we     = 1'b0;
        bus.cpu_addr   = 4'h0;
        bus.cpu_wdata  = 8'h00;
        bus.host_req   = 1'b0;
        bus.host_we    = 1'b0;
        bus.host_addr  = 4'h0;
        bus.host_wdata = 8'h00;

        // Reset state
        tick(); tick();
        check_idle_outputs("reset");
        check("reset mem_addr",  bus.mem_addr, 4'h0);
        check("reset mem_wdata", bus.mem_wdata, 8'h00);
        check("reset rdata", {bus.cpu_rdata, bus.host_rdata}, 16'h0000);
        rst = 1'b0;
        tick();
        check_idle_outputs("idle after reset");

        // CPU write 3 <= A5
        we_snap = we_cycles;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 4'h3; bus.cpu_wdata = 8'hA5;
        tick();
        check("wr gnt", {bus.cpu_gnt, bus.host_gnt}, 2'b10);
        check("wr strobes", {bus.mem_we, bus.mem_re}, 2'b10);
        check("wr addr", bus.mem_addr, 4'h3);
        check("wr data", bus.mem_wdata, 8'hA5);
        bus.cpu_req = 1'b0;
        tick();
        check_idle_outputs("wr capture");
        tick();
        check("wr done", {bus.cpu_done, bus.host_done}, 2'b10);
        check("wr no rdata change", bus.cpu_rdata, 8'h00);
        tick();
        check_idle_outputs("wr back to idle");
        check("wr mem_we cycles", we_cycles - we_snap, 1);

        // CPU read 3: req set in IDLE cycle 0, done in cycle 3
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 4'h3;
        tick();
        check("rd gnt", bus.cpu_gnt, 1'b1);
        check("rd strobes", {bus.mem_we, bus.mem_re}, 2'b01);
        bus.cpu_req = 1'b0;
        tick();
        check("rd capture done", bus.cpu_done, 1'b0);
        tick();
        check("rd done", bus.cpu_done, 1'b1);
        check("rd cpu_rdata", bus.cpu_rdata, 8'hA5);
        check("rd host_rdata", bus.host_rdata, 8'h00);
        tick();
        check_idle_outputs("rd idle");
        check("rd cpu_rdata held", bus.cpu_rdata, 8'hA5);

        // Both requesting from reset: cpu, host, cpu, host
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.cpu_req = 1'b1;  bus.cpu_we = 1'b0;  bus.cpu_addr = 4'h1;
        bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_addr = 4'h2;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("rr gnt %0d", k), {bus.cpu_gnt, bus.host_gnt},
                  (k % 2 == 0) ? 2'b10 : 2'b01);
            tick();
            check($sformatf("rr capture %0d", k), {bus.cpu_gnt, bus.host_gnt}, 2'b00);
            tick();
            check($sformatf("rr done %0d", k), {bus.cpu_done, bus.host_done},
                  (k % 2 == 0) ? 2'b10 : 2'b01);
        end
        bus.cpu_req = 1'b0; bus.host_req = 1'b0;
        tick();
        check_idle_outputs("rr idle");
        check("rr rdata", {bus.cpu_rdata, bus.host_rdata}, 16'h1122);

        // Host alone, 3 back-to-back reads at 1, 2, 3
        bus.host_req = 1'b1; bus.host_addr = 4'h1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("host gnt %0d", k), {bus.cpu_gnt, bus.host_gnt}, 2'b01);
            check($sformatf("host addr %0d", k), bus.mem_addr, k + 1);
            bus.host_addr = 4'(k + 2);
            tick();
            tick();
            check($sformatf("host done %0d", k), {bus.cpu_done, bus.host_done}, 2'b01);
            check($sformatf("host rdata %0d", k), bus.host_rdata,
                  (k == 0) ? 8'h11 : (k == 1) ? 8'h22 : 8'hA5);
            if (k == 2) bus.host_req = 1'b0;
        end
        tick();
        check_idle_outputs("host idle");
        check("host cpu_rdata untouched", bus.cpu_rdata, 8'h11);

        // CPU read 3 with addr/req changed during ACCESS
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 4'h3;
        tick();
        check("chg gnt", bus.cpu_gnt, 1'b1);
        check("chg addr access", bus.mem_addr, 4'h3);
        bus.cpu_addr = 4'h9; bus.cpu_req = 1'b0;
        tick();
        check("chg addr capture", bus.mem_addr, 4'h3);
        tick();
        check("chg done", bus.cpu_done, 1'b1);
        check("chg rdata", bus.cpu_rdata, 8'hA5);
        tick();
        check_idle_outputs("chg idle 1");
        tick();
        check_idle_outputs("chg idle 2");

        // Host reads 5, then CPU reads 6
        bus.host_req = 1'b1; bus.host_addr = 4'h5;
        tick();
        bus.host_req = 1'b0;
        tick(); tick();
        check("hc host done", bus.host_done, 1'b1);
        check("hc host rdata", bus.host_rdata, 8'h3C);
        bus.cpu_req = 1'b1; bus.cpu_addr = 4'h6;
        tick();
        check("hc cpu gnt", {bus.cpu_gnt, bus.host_gnt}, 2'b10);
        bus.cpu_req = 1'b0;
        tick(); tick();
        check("hc cpu done", bus.cpu_done, 1'b1);
        check("hc rdata pair", {bus.cpu_rdata, bus.host_rdata}, 16'h773C);
        tick();

        // Reset during CAPTURE of a CPU read
        bus.cpu_req = 1'b1; bus.cpu_addr = 4'h5;
        tick();
        bus.cpu_req = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        check_idle_outputs("async rst");
        check("async rst rdata", {bus.cpu_rdata, bus.host_rdata}, 16'h0000);
        check("async rst addr", bus.mem_addr, 4'h0);
        tick();
        rst = 1'b0;
        tick();
        check_idle_outputs("post rst 1");
        tick();
        check_idle_outputs("post rst 2");
        bus.cpu_req = 1'b1;  bus.cpu_addr = 4'h6;
        bus.host_req = 1'b1; bus.host_addr = 4'h5;
        tick();
        check("post rst tie gnt", {bus.cpu_gnt, bus.host_gnt}, 2'b10);
        bus.cpu_req = 1'b0; bus.host_req = 1'b0;
        tick(); tick();
        check("post rst done", {bus.cpu_done, bus.host_done}, 2'b10);
        check("post rst rdata", {bus.cpu_rdata, bus.host_rdata}, 16'h7700);
        tick();
        check_idle_outputs("final idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
